// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared sample format and vector widths for the network and its controller
package nn_pkg;

    localparam int W    = 17;
    localparam int NIN  = 7;
    localparam int XW   = NIN * W;

    // s4i12f: sign, 4 integer bits, 12 fractional bits
    typedef logic signed [W-1:0] sample_t;

endpackage

// File: rtl/nn_valid_pipe.sv
// rtl/nn_valid_pipe.sv - valid-tag shift register tracking samples through the network
module nn_valid_pipe #(
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               d,
    output logic [LATENCY-1:0] q
);

    logic [LATENCY-1:0] q_q;
    logic [LATENCY-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d[0] = d;
            for (int i = 1; i < LATENCY; i++) begin
                q_d[i] = q_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/nn_ctrl.sv
// rtl/nn_ctrl.sv - handshake/stall controller around a fixed-latency network
// NN_CTRL_STATS_EN adds a 32-bit delivered-sample counter on sample_cnt.
module nn_ctrl
    import nn_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int W       = nn_pkg::W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIN*W-1:0]  in_x,
    input  logic              flush,
    output logic              net_ce,
    output logic [NIN*W-1:0]  net_x,
    input  logic [W-1:0]      net_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_y,
`ifdef NN_CTRL_STATS_EN
    output logic [31:0]       sample_cnt,
`endif
    output logic              busy
);

    logic [NIN*W-1:0] net_x_q, net_x_d;
    logic [W-1:0]     out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;
    // bit 0 marks the sample sitting in net_x; bit LATENCY marks a settled net_y
    logic [LATENCY:0] vld;

    assign net_ce   = !(out_valid_q && !out_ready) && !flush;
    assign in_ready = net_ce;
    assign accept   = in_valid && net_ce;

    nn_valid_pipe #(
        .LATENCY (LATENCY + 1)
    ) u_valid_pipe (
        .clk (clk),
        .rst (rst),
        .en  (net_ce),
        .clr (flush),
        .d   (accept),
        .q   (vld)
    );

    always_comb begin
        net_x_d     = net_x_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            net_x_d = in_x;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (net_ce) begin
            out_valid_d = vld[LATENCY];
            if (vld[LATENCY]) begin
                out_y_d = net_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            net_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            net_x_q     <= net_x_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef NN_CTRL_STATS_EN
    logic [31:0] sample_cnt_q, sample_cnt_d;

    // counts every delivered handshake; flush does not clear it
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (out_valid_q && out_ready) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
`endif

    assign net_x     = net_x_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;
    assign busy      = (|vld) || out_valid_q;

endmodule

// File: tb/tb_nn_ctrl.sv
// tb/tb_nn_ctrl.sv - directed bench for nn_ctrl with a behavioural adder-tree network
module tb_nn_ctrl;
    import nn_pkg::*;

    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] in_x = '0;
    logic          flush = 1'b0;
    logic          net_ce;
    logic [XW-1:0] net_x;
    logic [W-1:0]  net_y;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_y;
    logic          busy;
`ifdef NN_CTRL_STATS_EN
    logic [31:0]   sample_cnt;
`endif

    int n_checks  = 0;
    int n_pass    = 0;
    int n_results = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] st[LAT];
    logic [14:0]  hist;
    int r0;

    always #5 clk = ~clk;

    nn_ctrl #(.LATENCY(LAT), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .flush      (flush),
        .net_ce     (net_ce),
        .net_x      (net_x),
        .net_y      (net_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
`ifdef NN_CTRL_STATS_EN
        .sample_cnt (sample_cnt),
`endif
        .busy       (busy)
    );

    function automatic logic [W-1:0] fsum(input logic [XW-1:0] x);
        logic [W-1:0] s = '0;
        for (int i = 0; i < NIN; i++) s = s + x[i*W +: W];
        return s;
    endfunction

    function automatic logic [XW-1:0] rep(input logic [W-1:0] v);
        logic [XW-1:0] r;
        for (int i = 0; i < NIN; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", busy, 0);
    endtask

    // network model: LAT-stage pipeline summing the seven inputs, enabled by net_ce
    initial for (int i = 0; i < LAT; i++) st[i] = '0;
    always @(posedge clk) begin
        if (net_ce) begin
            st[0] <= fsum(net_x);
            for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
        end
    end
    assign net_y = st[LAT-1];

    // scoreboard
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_results++;
                check("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("sb_data", out_y, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(fsum(in_x));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_net_x", net_x, 0);
        check("rst_out_y", out_y, 0);
`ifdef NN_CTRL_STATS_EN
        check("rst_cnt", sample_cnt, 0);
`endif
        #20 rst = 1'b0;
        step();
        check("post_rst_ce", net_ce, 1);
        check("post_rst_ready", in_ready, 1);

        // single sample latency
        in_valid = 1'b1;
        in_x = rep(17'h01000);
        step();
        in_valid = 1'b0;
        check("single_net_x", net_x, rep(17'h01000));
        step(); check("single_e1", out_valid, 0);
        step(); check("single_e2", out_valid, 0);
        step(); check("single_e3", out_valid, 1);
        check("single_y", out_y, 17'h07000);
        step(); check("single_e4", out_valid, 0);
        drain();

        // ten back-to-back samples
        for (int k = 0; k < 15; k++) begin
            if (k < 10) begin
                in_valid = 1'b1;
                in_x = rep(17'((k + 1) * 'h100));
                check("b2b_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            hist[k] = out_valid;
            if (k == 3)  check("b2b_first", out_y, 17'h00700);
            if (k == 12) check("b2b_last", out_y, 17'h04600);
        end
        check("b2b_pattern", hist, 15'h1FF8);
        drain();

        // output stall
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_x = rep(17'h10);
        step();
        in_x = rep(17'h20);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) step();
        check("stall_reach", out_valid, 1);
        in_valid = 1'b1;
        in_x = rep(17'h30);
        for (int i = 0; i < 5; i++) begin
            check("stall_ce", net_ce, 0);
            check("stall_ready", in_ready, 0);
            check("stall_y", out_y, 17'h70);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("unstall_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("unstall_valid", out_valid, 1);
        check("unstall_y", out_y, 17'hE0);
        drain();

        // flush with samples in flight
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_x = rep(17'(k));
            step();
        end
        in_x = rep(17'h55);
        flush = 1'b1;
        #1;
        check("flush_ready", in_ready, 0);
        check("flush_ce", net_ce, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_valid", out_valid, 0);
        check("flush_net_x", net_x, rep(17'h3));
        for (int i = 0; i < 6; i++) begin
            step();
            check("flush_no_stale", out_valid, 0);
        end

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        in_x = rep(17'h4);
        step();
        in_x = rep(17'h5);
        step();
        in_valid = 1'b0;
        #2;
        check("arst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_net_x", net_x, 0);
        step();
        step();
        #2 rst = 1'b0;
        step();
        r0 = n_results;
        in_valid = 1'b1;
        in_x = rep(17'h6);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("arst_one_result", n_results - r0, 1);
        drain();

`ifdef NN_CTRL_STATS_EN
        force dut.sample_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.sample_cnt_q;
        check("cnt_forced", sample_cnt, 32'hFFFFFFFE);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_x = rep(17'(k + 7));
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) step();
        step(); check("cnt_ffffffff", sample_cnt, 32'hFFFFFFFF);
        step(); check("cnt_wrap0", sample_cnt, 32'h0);
        step(); check("cnt_one", sample_cnt, 32'h1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
